// File: rtl/pipe_pkg.sv
// Shared pipeline widths and the ID/EX control bundle.
package pipe_pkg;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned REG_W   = 5;
    localparam int unsigned ALUOP_W = 3;

    typedef struct packed {
        logic               reg_write;
        logic               mem_to_reg;
        logic               mem_read;
        logic               mem_write;
        logic               branch;
        logic               alu_src;
        logic               reg_dst;
        logic [ALUOP_W-1:0] alu_op;
    } id_ex_ctrl_t;

    localparam id_ex_ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard: EX holds a load whose destination the ID instruction reads.
module load_use_detect #(
    parameter int unsigned REG_W = 5
) (
    input  logic             i_ex_valid,
    input  logic             i_ex_mem_read,
    input  logic [REG_W-1:0] i_ex_rt,
    input  logic             i_id_valid,
    input  logic             i_id_uses_rt,
    input  logic [REG_W-1:0] i_id_rs,
    input  logic [REG_W-1:0] i_id_rt,
    output logic             o_haz_c
);

    logic w_rs_match;
    logic w_rt_match;

    // $0 is hardwired to zero, so a load targeting it never creates a dependency
    assign w_rs_match = (i_ex_rt == i_id_rs);
    assign w_rt_match = i_id_uses_rt && (i_ex_rt == i_id_rt);
    assign o_haz_c    = i_ex_valid && i_ex_mem_read && (i_ex_rt != '0)
                        && (w_rs_match || w_rt_match) && i_id_valid;

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use bubble insertion and a saturating stall counter.
module id_ex_stage_reg #(
    parameter int unsigned DATA_W  = pipe_pkg::DATA_W,
    parameter int unsigned REG_W   = pipe_pkg::REG_W,
    parameter int unsigned ALUOP_W = pipe_pkg::ALUOP_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               hold_i,
    input  logic               flush_i,
    input  logic               ID_valid_i,
    input  logic               ID_uses_rt_i,
    input  logic [REG_W-1:0]   ID_rs_i,
    input  logic [REG_W-1:0]   ID_rt_i,
    input  logic [REG_W-1:0]   ID_rd_i,
    input  logic [DATA_W-1:0]  ID_rs_data_i,
    input  logic [DATA_W-1:0]  ID_rt_data_i,
    input  logic [DATA_W-1:0]  ID_imm_i,
    input  logic [DATA_W-1:0]  ID_pc4_i,
    input  logic               ID_reg_write_i,
    input  logic               ID_mem_to_reg_i,
    input  logic               ID_mem_read_i,
    input  logic               ID_mem_write_i,
    input  logic               ID_branch_i,
    input  logic               ID_alu_src_i,
    input  logic               ID_reg_dst_i,
    input  logic [ALUOP_W-1:0] ID_alu_op_i,
    output logic               EX_valid_o,
    output logic               EX_uses_rt_o,
    output logic [REG_W-1:0]   EX_rs_o,
    output logic [REG_W-1:0]   EX_rt_o,
    output logic [REG_W-1:0]   EX_rd_o,
    output logic [DATA_W-1:0]  EX_rs_data_o,
    output logic [DATA_W-1:0]  EX_rt_data_o,
    output logic [DATA_W-1:0]  EX_imm_o,
    output logic [DATA_W-1:0]  EX_pc4_o,
    output logic               EX_reg_write_o,
    output logic               EX_mem_to_reg_o,
    output logic               EX_mem_read_o,
    output logic               EX_mem_write_o,
    output logic               EX_branch_o,
    output logic               EX_alu_src_o,
    output logic               EX_reg_dst_o,
    output logic [ALUOP_W-1:0] EX_alu_op_o,
    output logic               pc_write_o,
    output logic               if_id_write_o,
    output logic [CNT_W-1:0]   stall_cnt_o
);

    import pipe_pkg::*;

    logic              r_valid;
    logic              r_uses_rt;
    logic [REG_W-1:0]  r_rs;
    logic [REG_W-1:0]  r_rt;
    logic [REG_W-1:0]  r_rd;
    logic [DATA_W-1:0] r_rs_data;
    logic [DATA_W-1:0] r_rt_data;
    logic [DATA_W-1:0] r_imm;
    logic [DATA_W-1:0] r_pc4;
    id_ex_ctrl_t       r_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;

    id_ex_ctrl_t       w_id_ctrl;
    logic              w_haz;

    assign w_id_ctrl = '{reg_write:  ID_reg_write_i,
                         mem_to_reg: ID_mem_to_reg_i,
                         mem_read:   ID_mem_read_i,
                         mem_write:  ID_mem_write_i,
                         branch:     ID_branch_i,
                         alu_src:    ID_alu_src_i,
                         reg_dst:    ID_reg_dst_i,
                         alu_op:     ID_alu_op_i};

    load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
        .i_ex_valid    (r_valid),
        .i_ex_mem_read (r_ctrl.mem_read),
        .i_ex_rt       (r_rt),
        .i_id_valid    (ID_valid_i),
        .i_id_uses_rt  (ID_uses_rt_i),
        .i_id_rs       (ID_rs_i),
        .i_id_rt       (ID_rt_i),
        .o_haz_c       (w_haz)
    );

    // Upstream may advance freely while reset is clearing this stage
    assign pc_write_o    = !rst_i || !(w_haz || hold_i);
    assign if_id_write_o = pc_write_o;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_valid     <= 1'b0;
            r_uses_rt   <= 1'b0;
            r_rs        <= '0;
            r_rt        <= '0;
            r_rd        <= '0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
            r_pc4       <= '0;
            r_ctrl      <= CTRL_BUBBLE;
            r_stall_cnt <= '0;
        end else if (!hold_i) begin
            if (flush_i || w_haz) begin
                r_valid   <= 1'b0;
                r_uses_rt <= 1'b0;
                r_rs      <= '0;
                r_rt      <= '0;
                r_rd      <= '0;
                r_rs_data <= '0;
                r_rt_data <= '0;
                r_imm     <= '0;
                r_pc4     <= '0;
                r_ctrl    <= CTRL_BUBBLE;
                // Only load-use bubbles are profiled, not branch squashes
                if (!flush_i && (r_stall_cnt != '1)) begin
                    r_stall_cnt <= r_stall_cnt + CNT_W'(1);
                end
            end else begin
                r_valid   <= ID_valid_i;
                r_uses_rt <= ID_uses_rt_i;
                r_rs      <= ID_rs_i;
                r_rt      <= ID_rt_i;
                r_rd      <= ID_rd_i;
                r_rs_data <= ID_rs_data_i;
                r_rt_data <= ID_rt_data_i;
                r_imm     <= ID_imm_i;
                r_pc4     <= ID_pc4_i;
                r_ctrl    <= w_id_ctrl;
            end
        end
    end

    assign EX_valid_o      = r_valid;
    assign EX_uses_rt_o    = r_uses_rt;
    assign EX_rs_o         = r_rs;
    assign EX_rt_o         = r_rt;
    assign EX_rd_o         = r_rd;
    assign EX_rs_data_o    = r_rs_data;
    assign EX_rt_data_o    = r_rt_data;
    assign EX_imm_o        = r_imm;
    assign EX_pc4_o        = r_pc4;
    assign EX_reg_write_o  = r_ctrl.reg_write;
    assign EX_mem_to_reg_o = r_ctrl.mem_to_reg;
    assign EX_mem_read_o   = r_ctrl.mem_read;
    assign EX_mem_write_o  = r_ctrl.mem_write;
    assign EX_branch_o     = r_ctrl.branch;
    assign EX_alu_src_o    = r_ctrl.alu_src;
    assign EX_reg_dst_o    = r_ctrl.reg_dst;
    assign EX_alu_op_o     = r_ctrl.alu_op;
    assign stall_cnt_o     = r_stall_cnt;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Randomised + directed bench for id_ex_stage_reg against a transaction-level model.
// A narrow stall counter keeps the saturation scenario within a short run.
module tb_id_ex_stage_reg;

    localparam int unsigned CW      = 8;
    localparam int unsigned CNT_MAX = (1 << CW) - 1;

    typedef struct packed {
        logic        valid;
        logic        uses_rt;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [31:0] pc4;
        logic        reg_write;
        logic        mem_to_reg;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        alu_src;
        logic        reg_dst;
        logic [2:0]  alu_op;
    } stage_t;

    logic clk = 1'b0;
    logic rst, hold, flush;
    stage_t id;
    stage_t dut_ex;
    logic [CW-1:0] stall_cnt;
    logic pc_write, if_id_write;

    logic        ex_valid, ex_uses_rt, ex_reg_write, ex_mem_to_reg, ex_mem_read;
    logic        ex_mem_write, ex_branch, ex_alu_src, ex_reg_dst;
    logic [4:0]  ex_rs, ex_rt, ex_rd;
    logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
    logic [2:0]  ex_alu_op;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    stage_t m_ex;
    int     m_cnt;

    always #5 clk = ~clk;

    id_ex_stage_reg #(.CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst), .hold_i(hold), .flush_i(flush),
        .ID_valid_i(id.valid), .ID_uses_rt_i(id.uses_rt),
        .ID_rs_i(id.rs), .ID_rt_i(id.rt), .ID_rd_i(id.rd),
        .ID_rs_data_i(id.rs_data), .ID_rt_data_i(id.rt_data),
        .ID_imm_i(id.imm), .ID_pc4_i(id.pc4),
        .ID_reg_write_i(id.reg_write), .ID_mem_to_reg_i(id.mem_to_reg),
        .ID_mem_read_i(id.mem_read), .ID_mem_write_i(id.mem_write),
        .ID_branch_i(id.branch), .ID_alu_src_i(id.alu_src),
        .ID_reg_dst_i(id.reg_dst), .ID_alu_op_i(id.alu_op),
        .EX_valid_o(ex_valid), .EX_uses_rt_o(ex_uses_rt),
        .EX_rs_o(ex_rs), .EX_rt_o(ex_rt), .EX_rd_o(ex_rd),
        .EX_rs_data_o(ex_rs_data), .EX_rt_data_o(ex_rt_data),
        .EX_imm_o(ex_imm), .EX_pc4_o(ex_pc4),
        .EX_reg_write_o(ex_reg_write), .EX_mem_to_reg_o(ex_mem_to_reg),
        .EX_mem_read_o(ex_mem_read), .EX_mem_write_o(ex_mem_write),
        .EX_branch_o(ex_branch), .EX_alu_src_o(ex_alu_src),
        .EX_reg_dst_o(ex_reg_dst), .EX_alu_op_o(ex_alu_op),
        .pc_write_o(pc_write), .if_id_write_o(if_id_write),
        .stall_cnt_o(stall_cnt)
    );

    assign dut_ex = {ex_valid, ex_uses_rt, ex_rs, ex_rt, ex_rd,
                     ex_rs_data, ex_rt_data, ex_imm, ex_pc4,
                     ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write,
                     ex_branch, ex_alu_src, ex_reg_dst, ex_alu_op};

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // A later instruction depends on a load still sitting in EX
    function automatic bit needs_stall(input stage_t ex, input stage_t nxt);
        if (!ex.valid || !ex.mem_read || ex.rt == 5'd0 || !nxt.valid) return 1'b0;
        return (nxt.rs == ex.rt) || (nxt.uses_rt && nxt.rt == ex.rt);
    endfunction

    // Reference model: one transaction per clock edge
    always @(posedge clk) begin
        if (!rst) begin
            m_ex  = '0;
            m_cnt = 0;
        end else if (hold) begin
            m_ex = m_ex;
        end else if (flush) begin
            m_ex = '0;
        end else if (needs_stall(m_ex, id)) begin
            m_ex = '0;
            if (m_cnt < CNT_MAX) m_cnt = m_cnt + 1;
        end else begin
            m_ex = id;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic exp_go;
            exp_go = !rst || !(needs_stall(m_ex, id) || hold);
            check("ex_fields", 256'(dut_ex), 256'(m_ex));
            check("stall_cnt", 256'(stall_cnt), 256'(m_cnt));
            check("pc_write", 256'(pc_write), 256'(exp_go));
            check("if_id_write", 256'(if_id_write), 256'(exp_go));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic stage_t rand_id();
        stage_t s;
        s.valid      = ($urandom_range(99) < 85);
        s.uses_rt    = 1'($urandom);
        s.rs         = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(3));
        s.rt         = ($urandom_range(3) == 0) ? 5'($urandom) : 5'($urandom_range(3));
        s.rd         = 5'($urandom);
        s.rs_data    = 32'($urandom);
        s.rt_data    = 32'($urandom);
        s.imm        = 32'($urandom);
        s.pc4        = 32'($urandom);
        s.reg_write  = 1'($urandom);
        s.mem_to_reg = 1'($urandom);
        s.mem_read   = ($urandom_range(99) < 40);
        s.mem_write  = 1'($urandom);
        s.branch     = 1'($urandom);
        s.alu_src    = 1'($urandom);
        s.reg_dst    = 1'($urandom);
        s.alu_op     = 3'($urandom);
        return s;
    endfunction

    function automatic stage_t mk(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                                  input bit uses_rt, input bit load);
        stage_t s = '0;
        s.valid     = 1'b1;
        s.uses_rt   = uses_rt;
        s.rs        = rs;
        s.rt        = rt;
        s.rd        = rd;
        s.rs_data   = 32'h1000_0000 | 32'(rs);
        s.rt_data   = 32'h2000_0000 | 32'(rt);
        s.imm       = 32'hFFFF_FFF0;
        s.pc4       = 32'h0040_0004;
        s.reg_write = 1'b1;
        s.mem_read  = load;
        s.mem_to_reg = load;
        s.alu_src   = load;
        s.reg_dst   = !load;
        s.alu_op    = load ? 3'd0 : 3'd2;
        return s;
    endfunction

    initial begin
        stage_t add3, add9, lw8, lw0, nop_rs0, lw5, addi, lw1, lw2;
        rst = 1'b0; hold = 1'b0; flush = 1'b0; id = rand_id();
        add3 = mk(5'd1, 5'd2, 5'd3, 1'b1, 1'b0);
        add9 = mk(5'd8, 5'd4, 5'd9, 1'b1, 1'b0);
        lw8  = mk(5'd2, 5'd8, 5'd0, 1'b0, 1'b1);
        lw0  = mk(5'd2, 5'd0, 5'd0, 1'b0, 1'b1);
        nop_rs0 = mk(5'd0, 5'd6, 5'd7, 1'b1, 1'b0);
        lw5  = mk(5'd2, 5'd5, 5'd0, 1'b0, 1'b1);
        addi = mk(5'd7, 5'd5, 5'd0, 1'b0, 1'b0);
        lw1  = mk(5'd3, 5'd1, 5'd0, 1'b0, 1'b1);
        lw2  = mk(5'd1, 5'd2, 5'd0, 1'b0, 1'b1);

        // reset with random ID traffic
        tick(); chk_en = 1'b1; id = rand_id();
        tick();
        check("reset_ex", 256'(dut_ex), 256'(0));
        check("reset_cnt", 256'(stall_cnt), 256'(0));
        check("reset_pc_write", 256'(pc_write), 256'(1));
        rst = 1'b1;

        // plain ALU instruction advances in one cycle
        id = add3; tick();
        check("add_ex", 256'(dut_ex), 256'(add3));
        check("add_rd", 256'(ex_rd), 256'(3));

        // load-use bubble: one stall, then the dependent add advances
        id = lw8; tick();
        id = add9; #1;
        check("lu_pc_write", 256'(pc_write), 256'(0));
        check("lu_if_id_write", 256'(if_id_write), 256'(0));
        tick();
        check("lu_bubble", 256'(dut_ex), 256'(0));
        check("lu_cnt", 256'(stall_cnt), 256'(1));
        tick();
        check("lu_advance", 256'(dut_ex), 256'(add9));

        // no stall for $0 destination or for an unread rt
        id = lw0; tick();
        id = nop_rs0; #1;
        check("rt0_no_stall", 256'(pc_write), 256'(1));
        tick();
        check("rt0_ex", 256'(dut_ex), 256'(nop_rs0));
        id = lw5; tick();
        id = addi; #1;
        check("addi_no_stall", 256'(pc_write), 256'(1));
        tick();
        check("addi_ex", 256'(dut_ex), 256'(addi));

        // flush beats hazard and is not counted
        id = lw8; tick();
        id = add9; flush = 1'b1; #1;
        check("flush_haz_pc_write", 256'(pc_write), 256'(0));
        tick();
        check("flush_bubble", 256'(dut_ex), 256'(0));
        check("flush_cnt", 256'(stall_cnt), 256'(1));
        flush = 1'b0;

        // hold beats flush; bubble appears once hold drops
        id = lw8; tick();
        hold = 1'b1; flush = 1'b1; id = add9; #1;
        check("hold_pc_write", 256'(pc_write), 256'(0));
        tick();
        check("hold_ex", 256'(dut_ex), 256'(lw8));
        hold = 1'b0; tick();
        check("hold_release_bubble", 256'(dut_ex), 256'(0));
        check("hold_release_cnt", 256'(stall_cnt), 256'(1));
        flush = 1'b0;

        // lw r1; lw r2,0(r1) stalls exactly once
        id = lw1; tick();
        id = lw2; tick();
        check("b2b_bubble", 256'(dut_ex), 256'(0));
        tick();
        check("b2b_second_load", 256'(dut_ex), 256'(lw2));
        id = mk(5'd5, 5'd6, 5'd7, 1'b1, 1'b0); tick();
        check("b2b_cnt", 256'(stall_cnt), 256'(2));

        // reset mid-stall clears state and ends the stall
        id = lw8; tick();
        id = add9; rst = 1'b0; #1;
        check("rst_stall_pc_write", 256'(pc_write), 256'(1));
        tick();
        check("rst_stall_ex", 256'(dut_ex), 256'(0));
        check("rst_stall_cnt", 256'(stall_cnt), 256'(0));
        rst = 1'b1; tick();
        check("rst_stall_resume", 256'(dut_ex), 256'(add9));

        // saturate the counter
        for (int i = 0; i < int'(CNT_MAX) + 4; i++) begin
            id = lw8; tick();
            id = add9; tick();
        end
        check("sat_cnt", 256'(stall_cnt), 256'(CNT_MAX));

        // random traffic against the model
        for (int i = 0; i < 1500; i++) begin
            id    = rand_id();
            flush = ($urandom_range(99) < 10);
            hold  = ($urandom_range(99) < 10);
            rst   = ($urandom_range(99) >= 2);
            tick();
        end
        rst = 1'b1; hold = 1'b0; flush = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
